mult_div_unit: RTL
==================

# mult_div_unit

Iterative MIPS multiply/divide unit owning the architectural HI and LO registers. Sits directly downstream of the register file: its operands come from the register-file read buses A and B, and it executes MULT, MULTU, DIV, DIVU, MTHI and MTLO. HI/LO feed the MFHI/MFLO path back toward write-back. A start/busy/done handshake lets the pipeline stall on HI/LO use while an operation is in flight.

## Interface
- No parameters; data width fixed at 32, iteration count fixed at 32.
- clk  in  1  single clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low; rst=0 clears all state immediately
- start  in  1  launch operation `op` on busA/busB; sampled only in IDLE
- op  in  2  MULT=0, MULTU=1, DIV=2, DIVU=3
- busA  in  32  operand rs (dividend / multiplicand); data source for MTHI/MTLO
- busB  in  32  operand rt (divisor / multiplier)
- hi_we  in  1  MTHI: HI <= busA
- lo_we  in  1  MTLO: LO <= busA
- hi  out  32  HI register
- lo  out  32  LO register
- busy  out  1  high whenever state != IDLE (decoded from state, no added latency)
- done  out  1  registered one-cycle pulse, high in the first cycle new HI/LO are visible

## Operation
- FSM states: IDLE, RUN, FIX.
- IDLE, start=1: latch operand magnitudes (MULT/DIV: two's-complement absolute value; MULTU/DIVU: raw), result signs, op, and special-case flags; counter <= 0; go to RUN.
- RUN: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle; 32 cycles; on count 31 go to FIX.
- FIX: apply sign correction and write HI/LO; done <= 1; go to IDLE.
- Multiply: 64-bit product, HI = bits 63:32, LO = bits 31:0. Signed product is negated iff operand signs differ.
- Divide: LO = quotient, HI = remainder. Quotient sign = XOR of operand signs; remainder sign = dividend sign; truncation toward zero.
- Divide by zero (busB=0, DIV or DIVU): no exception; full latency; HI = busA unchanged, LO = 32'hFFFF_FFFF.
- DIV 0x8000_0000 / 0xFFFF_FFFF: LO = 0x8000_0000, HI = 0.
- MTHI/MTLO: take effect at the edge they are sampled, in IDLE only; dropped while busy=1.
- In IDLE, start together with hi_we/lo_we: the write lands this edge; the operation's result overwrites it at FIX.
- hi_we and lo_we together: both written from busA.
- start while busy: ignored; no queueing.
- HI/LO hold their previous values throughout RUN; there are no partial updates.

## Timing
- Reset values: hi=0, lo=0, busy=0, done=0, state=IDLE, counter=0.
- start sampled at edge E0 → busy=1 from E0 through E33 → FIX writes at edge E33 → hi/lo/done valid in the cycle after E33 (latency 34 cycles), busy=0 in that same cycle.
- A new start may be accepted in the cycle done is high.
- done is high for exactly one cycle per accepted start.
- rst=0 mid-operation: immediate return to IDLE, outputs at reset values, no done.

## Structure
- Shared package `mips_pkg`: op encodings (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU) and the md state typedef/localparams.
- Single module with no sub-modules. Datapath: 64-bit accumulator/remainder-quotient register, 32-bit operand register, 5-bit counter, shared 33-bit adder/subtractor.

## Test plan
- Reset: drive rst=0 with random inputs → hi=0, lo=0, busy=0, done=0; release, idle 5 cycles → unchanged.
- MULT busA=0xFFFF_FFFF, busB=2 → done 34 cycles after start, hi=0xFFFF_FFFF, lo=0xFFFF_FFFE. MULTU, same operands → hi=1, lo=0xFFFF_FFFE.
- DIV busA=0xFFFF_FFF9 (-7), busB=2 → lo=0xFFFF_FFFD, hi=0xFFFF_FFFF. DIVU busA=7, busB=2 → lo=3, hi=1.
- DIVU busA=5, busB=0 → hi=5, lo=0xFFFF_FFFF. DIV 0x8000_0000 / 0xFFFF_FFFF → lo=0x8000_0000, hi=0.
- Handshake and writes, starting from an idle MTHI busA=0x1234 → hi=0x1234 next cycle.
  - start MULTU 3×4, then pulse start and hi_we at cycle 10 → both ignored; result hi=0, lo=12.
  - Back-to-back: start in the done cycle is accepted.
- Abort: rst=0 at cycle 10 of a DIV → busy=0 and hi=lo=0 immediately; done never asserts.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared multiply/divide op encodings and FSM state type.
package mips_pkg;
  localparam logic [1:0] MD_MULT  = 2'd0;
  localparam logic [1:0] MD_MULTU = 2'd1;
  localparam logic [1:0] MD_DIV   = 2'd2;
  localparam logic [1:0] MD_DIVU  = 2'd3;
  typedef enum logic [1:0] {MD_IDLE, MD_RUN, MD_FIX} md_state_e;
endpackage

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative 32-bit MIPS multiply/divide owning HI/LO.
// clk, rst (async active-low); start/op launch on busA/busB in IDLE;
// hi_we/lo_we load busA into HI/LO in IDLE; hi/lo registers; busy while
// not IDLE; done pulses in the first cycle new results are visible.
module mult_div_unit
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] busA,
  input  logic [31:0] busB,
  input  logic        hi_we,
  input  logic        lo_we,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done
);
  md_state_e   state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] opd_q, opd_d, hi_q, hi_d, lo_q, lo_d;
  logic        is_div_q, is_div_d, neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d, done_q, done_d;
  logic        sgn, a_neg, b_neg, b_zero;
  logic [31:0] a_mag, b_mag;
  logic [32:0] add_x, add_y, sum;
  logic [63:0] prod;
  assign sgn    = (op == MD_MULT) || (op == MD_DIV);
  assign a_neg  = sgn & busA[31];
  assign b_neg  = sgn & busB[31];
  assign b_zero = busB == 32'd0;
  assign a_mag  = a_neg ? -busA : busA;
  assign b_mag  = b_neg ? -busB : busB;
  // Divide: 33-bit trial subtract of divisor from the shifted remainder.
  // Multiply: add multiplicand to the upper product half.
  assign add_x = is_div_q ? acc_q[63:31] : {1'b0, acc_q[63:32]};
  assign add_y = is_div_q ? ~{1'b0, opd_q} : {1'b0, opd_q};
  assign sum   = add_x + add_y + {32'd0, is_div_q};
  assign prod  = neg_lo_q ? -acc_q : acc_q;
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opd_d    = opd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    done_d   = 1'b0;
    case (state_q)
      MD_IDLE: begin
        hi_d = hi_we ? busA : hi_q;
        lo_d = lo_we ? busA : lo_q;
        if (start) begin
          state_d  = MD_RUN;
          cnt_d    = 5'd0;
          is_div_d = op[1];
          acc_d    = {32'd0, op[1] ? a_mag : b_mag};
          opd_d    = op[1] ? b_mag : a_mag;
          // A zero divisor yields an all-ones quotient from the iteration
          // itself, so its sign flip is suppressed; the remainder is then busA.
          neg_lo_d = (a_neg ^ b_neg) & ~(op[1] & b_zero);
          neg_hi_d = op[1] ? a_neg : a_neg ^ b_neg;
        end
      end
      MD_RUN: begin
        cnt_d   = cnt_q + 5'd1;
        acc_d   = is_div_q ? (sum[32] ? {acc_q[62:0], 1'b0} : {sum[31:0], acc_q[30:0], 1'b1})
                           : {acc_q[0] ? sum : {1'b0, acc_q[63:32]}, acc_q[31:1]};
        state_d = cnt_q == 5'd31 ? MD_FIX : MD_RUN;
      end
      MD_FIX: begin
        hi_d    = is_div_q ? (neg_hi_q ? -acc_q[63:32] : acc_q[63:32]) : prod[63:32];
        lo_d    = is_div_q ? (neg_lo_q ? -acc_q[31:0] : acc_q[31:0]) : prod[31:0];
        done_d  = 1'b1;
        state_d = MD_IDLE;
      end
      default: state_d = MD_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= MD_IDLE;
      cnt_q    <= 5'd0;
      acc_q    <= 64'd0;
      opd_q    <= 32'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opd_q    <= opd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      done_q   <= done_d;
    end
  end
  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = state_q != MD_IDLE;
  assign done = done_q;
endmodule
